// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: fixed-priority writeback arbiter with aging promotion,
// a registered register-file write port and a saturating contention counter
module wb_port_arbiter #(
  parameter int N_REQ   = 4,
  parameter int XLEN    = 32,
  parameter int AGE_W   = 3,
  parameter int AGE_MAX = 7,
  parameter int IDX_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [5*N_REQ-1:0]    req_rd,
  input  logic [XLEN*N_REQ-1:0] req_data,
  input  logic                  wb_hold,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [IDX_W-1:0]      grant_idx,
  output logic [15:0]           conflict_cnt
);
  logic [AGE_W-1:0] age [N_REQ];
  logic [N_REQ-1:0] promo;
  logic [IDX_W-1:0] pidx, vidx, gidx;
  logic [4:0]       sel_rd;
  logic [XLEN-1:0]  sel_data;
  logic             xfer;
  always_comb begin
    promo = '0;
    pidx = '0;
    vidx = '0;
    sel_rd = '0;
    sel_data = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      promo[i] = req_valid[i] && age[i] == AGE_W'(AGE_MAX);
      pidx = promo[i] ? IDX_W'(i) : pidx;
      vidx = req_valid[i] ? IDX_W'(i) : vidx;
    end
    gidx = |promo ? pidx : vidx;
    xfer = rst_n && !wb_hold && |req_valid;
    req_ready = xfer ? N_REQ'(1) << gidx : '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_rd = IDX_W'(i) == gidx ? req_rd[5*i +: 5] : sel_rd;
      sel_data = IDX_W'(i) == gidx ? req_data[XLEN*i +: XLEN] : sel_data;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      grant_idx <= '0;
      conflict_cnt <= '0;
    end else begin
      rf_we <= xfer && sel_rd != '0;
      if (xfer) begin
        rf_waddr <= sel_rd;
        rf_wdata <= sel_data;
        grant_idx <= gidx;
      end
      if (!wb_hold && $countones(req_valid) >= 2 && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
  // ages freeze under hold so arbitration resumes where it left off
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (!rst_n || (!wb_hold && (!req_valid[i] || req_ready[i])))
        age[i] <= '0;
      else if (!wb_hold && age[i] != AGE_W'(AGE_MAX))
        age[i] <= age[i] + 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: vector table of grant patterns; a scoreboard derives the
// registered write-port outputs and contention count from the expected grants
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [19:0] req_rd;
  logic [127:0] req_data;
  logic        wb_hold;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  grant_idx;
  logic [15:0] conflict_cnt;
  logic [4:0]  rd [4];
  logic [31:0] dat [4];
  typedef struct { logic [3:0] v; logic h; logic r; logic [3:0] rdy; } vec_t;
  typedef struct { logic we; logic [4:0] a; logic [31:0] d; logic [1:0] g; logic [15:0] c; } exp_t;
  vec_t vecs[$];
  exp_t sbq[$];
  logic [4:0]  m_a;
  logic [31:0] m_d;
  logic [1:0]  m_g;
  logic [15:0] m_c;
  int checks = 0;
  int errors = 0;

  wb_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data), .wb_hold(wb_hold), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .grant_idx(grant_idx),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;
  always_comb begin
    req_rd = {rd[3], rd[2], rd[1], rd[0]};
    req_data = {dat[3], dat[2], dat[1], dat[0]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] v, input logic h, input logic r, input logic [3:0] rdy, input int n);
    for (int k = 0; k < n; k++) vecs.push_back('{v: v, h: h, r: r, rdy: rdy});
  endtask

  task automatic step(input vec_t t);
    exp_t e;
    req_valid = t.v;
    wb_hold = t.h;
    rst_n = t.r;
    #1;
    check("req_ready", 32'(req_ready), 32'(t.rdy));
    e.we = 1'b0;
    if (!t.r) begin
      m_a = '0; m_d = '0; m_g = '0; m_c = '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (t.rdy[i]) begin
          m_a = rd[i]; m_d = dat[i]; m_g = 2'(i); e.we = rd[i] != 0;
        end
      if (!t.h && $countones(t.v) >= 2 && m_c != 16'hFFFF) m_c = m_c + 1'b1;
    end
    e.a = m_a; e.d = m_d; e.g = m_g; e.c = m_c;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check("rf_we", 32'(rf_we), 32'(e.we));
    check("rf_waddr", 32'(rf_waddr), 32'(e.a));
    check("rf_wdata", rf_wdata, e.d);
    check("grant_idx", 32'(grant_idx), 32'(e.g));
    check("conflict_cnt", 32'(conflict_cnt), 32'(e.c));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rd[0] = 5'd1; dat[0] = 32'h11111111;
    rd[1] = 5'd5; dat[1] = 32'hDEADBEEF;
    rd[2] = 5'd7; dat[2] = 32'h22222222;
    rd[3] = 5'd0; dat[3] = 32'h00001234;
    m_a = '0; m_d = '0; m_g = '0; m_c = '0;
    // reset twice so all state is known before the table starts
    step('{v: 4'b0011, h: 1'b0, r: 1'b0, rdy: 4'b0000});
    step('{v: 4'b0000, h: 1'b0, r: 1'b0, rdy: 4'b0000});
    add(4'b0010, 0, 1, 4'b0010, 1);
    add(4'b0000, 0, 1, 4'b0000, 1);
    add(4'b1000, 0, 1, 4'b1000, 1);
    add(4'b0010, 1, 1, 4'b0000, 3);
    add(4'b0010, 0, 1, 4'b0010, 1);
    add(4'b0000, 0, 1, 4'b0000, 1);
    add(4'b0101, 0, 1, 4'b0001, 7);
    add(4'b0101, 0, 1, 4'b0100, 1);
    add(4'b0101, 0, 1, 4'b0001, 1);
    add(4'b0000, 0, 1, 4'b0000, 1);
    add(4'b0011, 0, 1, 4'b0001, 7);
    add(4'b0011, 0, 1, 4'b0010, 1);
    add(4'b0011, 0, 1, 4'b0001, 2);
    add(4'b0011, 1, 1, 4'b0000, 2);
    add(4'b0011, 0, 1, 4'b0001, 1);
    add(4'b0001, 0, 1, 4'b0001, 1);
    foreach (vecs[i]) step(vecs[i]);
    // reset mid-stream with a grant just accepted and req1 aged
    step('{v: 4'b0011, h: 1'b0, r: 1'b1, rdy: 4'b0001});
    step('{v: 4'b0011, h: 1'b0, r: 1'b0, rdy: 4'b0000});
    // a freshly reset age1 needs the full 7 cycles before promotion
    for (int k = 0; k < 7; k++) step('{v: 4'b0011, h: 1'b0, r: 1'b1, rdy: 4'b0001});
    step('{v: 4'b0011, h: 1'b0, r: 1'b1, rdy: 4'b0010});
    // hold right after a grant still lets the accepted write land
    step('{v: 4'b0100, h: 1'b0, r: 1'b1, rdy: 4'b0100});
    step('{v: 4'b0100, h: 1'b1, r: 1'b1, rdy: 4'b0000});
    step('{v: 4'b0000, h: 1'b0, r: 1'b1, rdy: 4'b0000});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
